// File: rtl/bar_position_ctrl_if.sv
// bar_position_ctrl_if: custom-instruction handshake between the processor and bar_position_ctrl.
// Ports: ci_start/dataa carry a request to the controller; ci_done/result acknowledge it.
// The master modport is the processor side and the slave modport is the controller side.
interface bar_position_ctrl_if;
  logic        ci_start;
  logic [31:0] dataa;
  logic        ci_done;
  logic [31:0] result;

  modport master (output ci_start, output dataa, input ci_done, input result);
  modport slave  (input ci_start, input dataa, output ci_done, output result);
endinterface

// File: rtl/bar_position_ctrl.sv
// bar_position_ctrl: queues paddle-bar y updates and commits both bars atomically at a frame boundary.
// Latency: ci_start -> ci_done is at least 2 cycles. frame_stb -> y_bar update is fifo_level+2 cycles.
// Backpressure: a request stays in the pending register while the FIFO is full or a drain runs; ci_done is deferred until then.
// Ports: CLK, RST_BTN (async, active-low); ci (slave: ci_start, dataa[10]=bar select, dataa[9:0]=y, ci_done,
//        result={16'b0,frame_cnt}); frame_stb (start of vblank); y_bar1/y_bar2 (committed positions);
//        fifo_level (queue occupancy).
// Optional: define CLAMP_EN to clamp y to Y_MAX-BAR_H at enqueue time. Otherwise y passes unmodified.
module bar_position_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int Y_MAX      = 480,
  parameter int BAR_H      = 60,
  parameter int RESET_Y    = 210
) (
  input  logic                 CLK,
  input  logic                 RST_BTN,
  bar_position_ctrl_if.slave   ci,
  input  logic                 frame_stb,
  output logic [9:0]           y_bar1,
  output logic [9:0]           y_bar2,
  output logic [2:0]           fifo_level
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [9:0] Y_RST  = 10'(RESET_Y);
`ifdef CLAMP_EN
  localparam logic [9:0] Y_CEIL = 10'(Y_MAX - BAR_H);
`endif

  typedef struct packed {
    logic       sel;   // 0 = bar 1, 1 = bar 2
    logic [9:0] y;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_PUBLISH
  } state_t;

  state_t          state, state_nxt;
  entry_t          pending, wr_entry, rd_entry;
  logic            pending_v;
  entry_t          mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [9:0]      work1, work2;
  logic [15:0]     frame_cnt;
  logic            full, empty, do_write, do_pop;

  // Upper instruction operand bits carry nothing for this block.
  logic unused_dataa;
  assign unused_dataa = ^ci.dataa[31:11];

  assign full       = (count == CW'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign rd_entry   = mem[rd_ptr];
  assign fifo_level = 3'(count);

  // Writes are held off during a drain so the queue being committed stays fixed.
  // This also means a write and a pop never coincide.
  assign do_write = pending_v && !full && (state != ST_DRAIN);

  always_comb begin
    wr_entry = pending;
`ifdef CLAMP_EN
    if (pending.y > Y_CEIL) wr_entry.y = Y_CEIL;
`endif
  end

  always_ff @(posedge CLK or negedge RST_BTN) begin
    if (!RST_BTN) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_pop    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (frame_stb && !empty) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        do_pop = !empty;
        // The last entry is popped this cycle, so publish next.
        if (count <= CW'(1)) state_nxt = ST_PUBLISH;
      end
      ST_PUBLISH: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // FIFO storage has no reset; occupancy is tracked by count and the pointers.
  always_ff @(posedge CLK) begin
    if (do_write) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge CLK or negedge RST_BTN) begin
    if (!RST_BTN) begin
      pending    <= '0;
      pending_v  <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      work1      <= Y_RST;
      work2      <= Y_RST;
      y_bar1     <= Y_RST;
      y_bar2     <= Y_RST;
      frame_cnt  <= '0;
      ci.ci_done <= 1'b0;
      ci.result  <= '0;
    end else begin
      // A start while a request is already pending is dropped.
      if (do_write) begin
        pending_v <= 1'b0;
      end else if (ci.ci_start && !pending_v) begin
        pending   <= entry_t'(ci.dataa[10:0]);
        pending_v <= 1'b1;
      end

      ci.ci_done <= do_write;
      if (do_write) ci.result <= {16'b0, frame_cnt};

      if (frame_stb) frame_cnt <= frame_cnt + 16'd1;

      if (do_write) begin
        wr_ptr <= wr_ptr + AW'(1);
        count  <= count + CW'(1);
      end else if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        count  <= count - CW'(1);
      end

      // Entries are applied in FIFO order, so the last write to a bar wins.
      if (do_pop) begin
        if (rd_entry.sel) work2 <= rd_entry.y;
        else              work1 <= rd_entry.y;
      end

      if (state == ST_PUBLISH) begin
        y_bar1 <= work1;
        y_bar2 <= work2;
      end
    end
  end

endmodule

// File: tb/tb_bar_position_ctrl.sv
// tb_bar_position_ctrl: self-checking bench for bar_position_ctrl.
// Table-driven single updates, followed by hand-written multi-cycle sequences.
// ci_done/result are checked by a scoreboard queue filled when requests are driven.
module tb_bar_position_ctrl;

  logic       CLK = 1'b0;
  logic       RST_BTN;
  logic       frame_stb;
  logic [9:0] y_bar1, y_bar2;
  logic [2:0] fifo_level;

  bar_position_ctrl_if ci_bus ();

  bar_position_ctrl dut (
    .CLK        (CLK),
    .RST_BTN    (RST_BTN),
    .ci         (ci_bus),
    .frame_stb  (frame_stb),
    .y_bar1     (y_bar1),
    .y_bar2     (y_bar2),
    .fifo_level (fifo_level)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int done_count = 0;
  int last_done_cyc = 0;
  int done_before = 0;
  int start_cyc = 0;
  int fc = 0;
  logic [9:0] cur_y1, cur_y2;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] dataa;
    logic [9:0]  y1;
    logic [9:0]  y2;
  } vec_t;
  vec_t vec [8];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Scoreboard side: every ci_done must match the oldest expected result.
  always @(negedge CLK) begin
    if (ci_bus.ci_done) begin
      done_count++;
      last_done_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_ci_done", 32'd1, 32'd0);
      end else begin
        check("ci_result", ci_bus.result, exp_q.pop_front());
      end
    end
  end

  function automatic logic [9:0] exp_y(input logic [9:0] y);
`ifdef CLAMP_EN
    return (y > 10'd420) ? 10'd420 : y;
`else
    return y;
`endif
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input int exp_fc);
    exp_q.push_back({16'b0, 16'(exp_fc)});
    done_before = done_count;
    start_cyc   = cyc;
    ci_bus.ci_start = 1'b1;
    ci_bus.dataa    = d;
    step();
    ci_bus.ci_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input bit chk_lat);
    for (int i = 0; i < 40 && done_count == done_before; i++) step();
    check({name, "_done_seen"}, done_count, done_before + 1);
    if (chk_lat) check({name, "_latency"}, last_done_cyc - start_cyc, 2);
  endtask

  task automatic pulse_frame();
    frame_stb = 1'b1;
    step();
    frame_stb = 1'b0;
    fc++;
  endtask

  // After pulse_frame: n cycles with old values, then both bars change together.
  task automatic commit_check(input string name, input int n, input logic [9:0] n1, input logic [9:0] n2);
    for (int i = 0; i < n; i++) begin
      step();
      check({name, "_hold_y1"}, y_bar1, cur_y1);
      check({name, "_hold_y2"}, y_bar2, cur_y2);
    end
    step();
    check({name, "_new_y1"}, y_bar1, n1);
    check({name, "_new_y2"}, y_bar2, n2);
    cur_y1 = n1;
    cur_y2 = n2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0] = '{32'h0000_0064, 10'd100, 10'd210};
    vec[1] = '{32'h0000_052C, 10'd100, 10'd300};
    vec[2] = '{32'h0000_0000, 10'd0,   10'd300};
    vec[3] = '{32'hFFFF_F9A4, 10'd420, 10'd300};
    vec[4] = '{32'h0000_07FF, 10'd420, exp_y(10'd1023)};
    vec[5] = '{32'h0000_03FF, exp_y(10'd1023), exp_y(10'd1023)};
    vec[6] = '{32'h0000_01A5, exp_y(10'd421),  exp_y(10'd1023)};
    vec[7] = '{32'h0000_0400, exp_y(10'd421),  10'd0};

    RST_BTN = 1'b0;
    ci_bus.ci_start = 1'b0;
    ci_bus.dataa    = '0;
    frame_stb       = 1'b0;
    repeat (3) step();
    check("rst_y1", y_bar1, 210);
    check("rst_y2", y_bar2, 210);
    check("rst_level", fifo_level, 0);
    check("rst_ci_done", ci_bus.ci_done, 0);
    check("rst_result", ci_bus.result, 0);
    RST_BTN = 1'b1;
    cur_y1 = 10'd210;
    cur_y2 = 10'd210;
    step();

    // Single updates from the table.
    for (int i = 0; i < 8; i++) begin
      send(vec[i].dataa, fc);
      wait_done($sformatf("vec%0d", i), 1'b1);
      check($sformatf("vec%0d_level", i), fifo_level, 1);
      pulse_frame();
      commit_check($sformatf("vec%0d", i), 1, vec[i].y1, vec[i].y2);
      check($sformatf("vec%0d_level_after", i), fifo_level, 0);
    end

    // Atomic pair with last-wins.
    send(32'h032, fc); wait_done("pair_a", 1'b1);
    send(32'h52C, fc); wait_done("pair_b", 1'b1);
    send(32'h046, fc); wait_done("pair_c", 1'b1);
    check("pair_level", fifo_level, 3);
    repeat (3) step();
    check("pair_pre_y1", y_bar1, cur_y1);
    check("pair_pre_y2", y_bar2, cur_y2);
    pulse_frame();
    commit_check("pair", 3, 10'd70, 10'd300);
    check("pair_level_after", fifo_level, 0);

    // Full FIFO back-pressure.
    send(32'h00B, fc); wait_done("full_1", 1'b1);
    send(32'h00C, fc); wait_done("full_2", 1'b1);
    send(32'h00D, fc); wait_done("full_3", 1'b1);
    send(32'h40E, fc); wait_done("full_4", 1'b1);
    check("full_level", fifo_level, 4);
    send(32'h063, fc + 1);
    repeat (6) step();
    check("full_withheld", done_count, done_before);
    check("full_level_hold", fifo_level, 4);
    pulse_frame();
    commit_check("full_drain", 4, 10'd13, 10'd14);
    wait_done("full_5", 1'b0);
    check("full_level_5th", fifo_level, 1);
    check("full_5th_not_applied", y_bar1, 13);
    pulse_frame();
    commit_check("full_5th", 1, 10'd99, 10'd14);

    // Collision of ci_start and frame_stb with one entry queued.
    send(32'h0C8, fc); wait_done("coll_q", 1'b1);
    exp_q.push_back({16'b0, 16'(fc + 1)});
    done_before = done_count;
    ci_bus.ci_start = 1'b1;
    ci_bus.dataa    = 32'h47B;
    frame_stb       = 1'b1;
    step();
    ci_bus.ci_start = 1'b0;
    frame_stb       = 1'b0;
    fc++;
    commit_check("coll_old", 1, 10'd200, cur_y2);
    wait_done("coll_new", 1'b0);
    check("coll_level", fifo_level, 1);
    pulse_frame();
    commit_check("coll_next", 1, 10'd200, 10'd123);

    // Second start while a request is pending is dropped.
    send(32'h011, fc);
    ci_bus.ci_start = 1'b1;
    ci_bus.dataa    = 32'h022;
    step();
    ci_bus.ci_start = 1'b0;
    repeat (8) step();
    check("ignore_done_count", done_count, done_before + 1);
    check("ignore_level", fifo_level, 1);
    pulse_frame();
    commit_check("ignore", 1, 10'd17, 10'd123);

    // Asynchronous reset with two queued entries and one pending request.
    send(32'h005, fc); wait_done("rst_q1", 1'b1);
    send(32'h406, fc); wait_done("rst_q2", 1'b1);
    ci_bus.ci_start = 1'b1;
    ci_bus.dataa    = 32'h0C8;
    step();
    ci_bus.ci_start = 1'b0;
    RST_BTN = 1'b0;
    #1;
    check("mid_rst_y1", y_bar1, 210);
    check("mid_rst_y2", y_bar2, 210);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_ci_done", ci_bus.ci_done, 0);
    repeat (3) step();
    RST_BTN = 1'b1;
    fc = 0;
    cur_y1 = 10'd210;
    cur_y2 = 10'd210;
    done_before = done_count;
    repeat (8) step();
    check("post_rst_no_done", done_count, done_before);
    pulse_frame();
    repeat (4) step();
    check("post_rst_y1", y_bar1, 210);
    check("post_rst_y2", y_bar2, 210);
    check("post_rst_level", fifo_level, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bar_position_ctrl.md
Name: bar_position_ctrl

Overview:
- Sequences paddle-bar position updates from the processor custom-instruction interface into the two bar-drawing instances.
- Requests are queued in a small FIFO and committed atomically at a frame boundary, so a bar never tears mid-frame.
- Sits between the processor custom instruction and the yBar1/yBar2 inputs of the bar renderers in the VGA top level.

Parameters:
- FIFO_DEPTH, 4, queued update entries; power of two, minimum 2.
- Y_MAX, 480, visible lines per frame.
- BAR_H, 60, bar height in lines; clamp ceiling is Y_MAX-BAR_H.
- RESET_Y, 210, reset position of both bars.

Ports:
- CLK  input  1  system clock; all logic on posedge.
- RST_BTN  input  1  reset, asynchronous, active-low.
- ci_start  input  1  single-cycle custom-instruction start strobe.
- dataa  input  32  [10] bar select (0=bar1, 1=bar2), [9:0] requested y, [31:11] ignored.
- ci_done  output  1  one-cycle pulse when the request is accepted into the FIFO.
- result  output  32  {16'b0, frame_cnt[15:0]}, valid while ci_done is high.
- frame_stb  input  1  one-cycle pulse at end of active area (start of vblank).
- y_bar1  output  10  committed bar-1 y position.
- y_bar2  output  10  committed bar-2 y position.
- fifo_level  output  3  current FIFO occupancy, 0..FIFO_DEPTH.

Behaviour:
- Reset (RST_BTN low, asynchronous): FIFO empty, pending clear, FSM=IDLE, y_bar1=y_bar2=RESET_Y, working copies=RESET_Y, ci_done=0, result=0, frame_cnt=0. Reset mid-drain or with a pending request discards everything; no ci_done is issued.
- Pending register: ci_start loads pending={dataa[10:0]} and sets pending_v. A ci_start while pending_v=1 is a protocol error and is ignored.
- Enqueue: when pending_v=1, FIFO not full, and FSM≠DRAIN, the entry is written and pending_v clears. ci_done pulses the following cycle with result={16'b0,frame_cnt}.
  - Minimum latency from ci_start to ci_done is 2 cycles.
  - If the FIFO is full or a drain is in progress, the request stays pending and ci_done is deferred until the write occurs.
- frame_cnt: increments on every frame_stb and wraps at 16 bits.
- FSM:
  - IDLE: on frame_stb, go to DRAIN if the FIFO is non-empty, otherwise stay in IDLE.
  - DRAIN: pop one entry per cycle. Select bit 0 updates work1, select bit 1 updates work2. Stay in DRAIN until the FIFO is empty after a pop, then go to PUBLISH.
  - PUBLISH: y_bar1<=work1, y_bar2<=work2 in the same cycle, then go to IDLE.
  - frame_stb received in DRAIN or PUBLISH is ignored (counted only).
- Ordering: FIFO order is preserved; the last write to a bar within one drain wins.
- Latency from frame_stb to output update is fifo_level+2 cycles, worst case FIFO_DEPTH+2.
- ci_start and frame_stb in the same cycle: pending is loaded and the drain starts. The pending entry is held until PUBLISH→IDLE and applies next frame.
- fifo_level is updated on write and pop; a simultaneous write and pop cannot occur because writes are blocked in DRAIN.

Optional Feature:
- CLAMP_EN defined: the y value is clamped at enqueue time to min(dataa[9:0], Y_MAX-BAR_H), so 1023→420 with defaults.
- CLAMP_EN undefined: dataa[9:0] passes unmodified.

Test Plan:
- Reset: assert RST_BTN=0 mid-simulation with 2 entries queued -> y_bar1=y_bar2=210, fifo_level=0, ci_done=0 immediately, no later ci_done.
- Single update: ci_start with dataa=0x064 -> ci_done 2 cycles later with result=frame_cnt. Next frame_stb -> y_bar1=100 exactly 3 cycles later, y_bar2 unchanged at 210.
- Atomic pair with last-wins: enqueue bar1=50, bar2=300, bar1=70 -> no output change before frame_stb. After frame_stb, y_bar1=70 and y_bar2=300 change in the same cycle, 5 cycles after the strobe.
- Full FIFO back-pressure: 4 enqueues then a 5th ci_start -> fifo_level=4, 5th ci_done withheld. After frame_stb drain and publish, the 5th is enqueued and ci_done pulses; its value appears only after the following frame_stb.
- Collision: ci_start and frame_stb in the same cycle with 1 entry queued -> the existing entry is published. The new entry is accepted after the drain and published next frame, and frame_cnt increments by 1.
- CLAMP_EN: dataa=0x3FF -> y_bar1=420 after commit. Without CLAMP_EN -> y_bar1=1023.
